// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (core datapath and loader/debug port) for the shared
// instruction/data memory: round-robin grant, loader burst lock, m_ack timeout.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 16,
  parameter logic [DW-1:0] ERR_DATA = DW'(32'hDEADBEEF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_ack,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  input  logic          l_lock,
  output logic [DW-1:0] l_rdata,
  output logic          l_ack,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          busy,
  output logic          timeout_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, CORE, LDR, DONE} state_t;

  state_t        state_q, state_d;
  logic          last_ldr_q;   // 1 = loader held the most recent grant
  logic          lock_q;
  logic [CW-1:0] cnt_q;
  logic          start, pick_ldr, to_hit;

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    pick_ldr = 1'b0;
    to_hit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (c_req && l_req) begin
          start    = 1'b1;
          pick_ldr = lock_q || !last_ldr_q;
        end else if (c_req) begin
          start = 1'b1;
        end else if (l_req) begin
          start    = 1'b1;
          pick_ldr = 1'b1;
        end
        if (start) state_d = pick_ldr ? LDR : CORE;
      end
      CORE, LDR: begin
        to_hit = (TIMEOUT > 0) && !m_ack && (cnt_q == TO_LAST);
        if (m_ack || to_hit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_ldr_q  <= 1'b1;
      lock_q      <= 1'b0;
      cnt_q       <= '0;
      m_we        <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      c_rdata     <= '0;
      l_rdata     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          // A lock only survives while the loader keeps its request up.
          if (!l_req) lock_q <= 1'b0;
          if (start) begin
            last_ldr_q <= pick_ldr;
            lock_q     <= pick_ldr && l_lock;
            m_we       <= pick_ldr ? l_we    : c_we;
            m_addr     <= pick_ldr ? l_addr  : c_addr;
            m_wdata    <= pick_ldr ? l_wdata : c_wdata;
          end
        end
        CORE, LDR: begin
          if (!m_ack) cnt_q <= cnt_q + 1'b1;
          if (m_ack) begin
            if (!m_we) begin
              if (state_q == LDR) l_rdata <= m_rdata;
              else                c_rdata <= m_rdata;
            end
          end else if (to_hit) begin
            timeout_err <= 1'b1;
            if (!m_we) begin
              if (state_q == LDR) l_rdata <= ERR_DATA;
              else                c_rdata <= ERR_DATA;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Memory strobe and acks decode straight from state so reset kills them at once.
  assign m_req = (state_q == CORE) || (state_q == LDR);
  assign busy  = (state_q != IDLE);
  assign c_ack = (state_q == DONE) && !last_ldr_q;
  assign l_ack = (state_q == DONE) &&  last_ldr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: reactive memory model, per-requester expected
// rdata queues checked by an ack monitor, directed scenarios plus random traffic.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 16;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic reset;
  logic c_req, c_we, c_ack;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic l_req, l_we, l_lock, l_ack;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic m_req, m_we, m_ack;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic busy, timeout_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ack(c_ack),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_lock(l_lock), .l_rdata(l_rdata), .l_ack(l_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .busy(busy), .timeout_err(timeout_err)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem     [logic [31:0]];   // contents held by the memory model
  logic [31:0] ref_mem [logic [31:0]];   // what each requester expects to read back
  logic [31:0] c_q[$];
  logic [31:0] l_q[$];
  logic [31:0] last_c, last_l;
  bit hang, rand_lat;
  int fixed_lat;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  // Memory model: answers after a per-access latency, or never while hang=1.
  bit in_txn, stable_ok;
  int waited, cur_lat;
  logic [31:0] s_addr, s_wd;
  logic s_we;
  initial begin
    m_ack = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset || !m_req) begin
        in_txn = 1'b0;
        m_ack = 1'b0;
      end else begin
        if (!in_txn) begin
          in_txn = 1'b1;
          waited = 0;
          cur_lat = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
          s_addr = m_addr; s_we = m_we; s_wd = m_wdata;
          stable_ok = 1'b1;
        end else if (m_addr !== s_addr || m_we !== s_we || m_wdata !== s_wd) begin
          stable_ok = 1'b0;
        end
        if (!hang && waited >= cur_lat) begin
          m_ack = 1'b1;
          if (s_we) begin
            mem[s_addr] = s_wd;
            m_rdata = $urandom;
          end else begin
            m_rdata = mem_rd(s_addr);
          end
          check("m_fields_held", 32'(stable_ok), 1);
        end else begin
          m_ack = 1'b0;
          waited++;
        end
      end
    end
  end

  // Ack monitor: pops the expected read data for whichever requester is acked.
  initial begin
    forever begin
      @(negedge clk);
      if (c_ack || l_ack) check("ack_exclusive", 32'(c_ack & l_ack), 0);
      if (c_ack) begin
        if (c_q.size() == 0) check("c_ack_unexpected", 32'(c_ack), 0);
        else check("c_rdata", c_rdata, c_q.pop_front());
      end
      if (l_ack) begin
        if (l_q.size() == 0) check("l_ack_unexpected", 32'(l_ack), 0);
        else check("l_rdata", l_rdata, l_q.pop_front());
      end
    end
  end

  task automatic core_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output int n, output int ack_cyc);
    logic [31:0] e;
    @(negedge clk);
    c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wd;
    if (we) begin
      if (!hang) ref_mem[addr] = wd;
      e = last_c;
    end else begin
      e = hang ? ERR : ref_rd(addr);
      last_c = e;
    end
    c_q.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!c_ack && n < 300);
    ack_cyc = cyc;
    check("c_ack_seen", 32'(c_ack), 1);
    c_req = 1'b0;
  endtask

  task automatic ldr_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic lock, output int n, output int ack_cyc);
    logic [31:0] e;
    @(negedge clk);
    l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = wd; l_lock = lock;
    if (we) begin
      if (!hang) ref_mem[addr] = wd;
      e = last_l;
    end else begin
      e = hang ? ERR : ref_rd(addr);
      last_l = e;
    end
    l_q.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!l_ack && n < 300);
    ack_cyc = cyc;
    check("l_ack_seen", 32'(l_ack), 1);
    l_req = 1'b0;
    l_lock = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_m_req", 32'(m_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_acks", {30'b0, c_ack, l_ack}, 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    check("rst_c_rdata", c_rdata, 0);
    check("rst_l_rdata", l_rdata, 0);
    check("rst_m_addr", m_addr, 0);
    reset = 1'b0;
    last_c = '0;
    last_l = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish by 300000");
    $fatal(1, "watchdog expired");
  end

  int n, n2, n3, t1, t2, t3;
  initial begin
    reset = 1'b1;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0; l_lock = 0;
    hang = 0; rand_lat = 0; fixed_lat = 0;
    mem[32'h10] = 32'h00500093;
    ref_mem[32'h10] = 32'h00500093;
    do_reset();

    // Lone core read, single-cycle memory
    core_txn(1'b0, 32'h10, '0, n, t1);
    check("core_rd_latency", n, 2);

    // Simultaneous requests right after reset: core first, loader 3 cycles later
    do_reset();
    fork
      core_txn(1'b0, 32'h210, '0, n, t1);
      ldr_txn(1'b0, 32'h310, '0, 1'b0, n2, t2);
    join
    check("contention_gap", t2 - t1, 3);

    // Loader locked burst holds off a continuously requesting core
    fork
      begin
        ldr_txn(1'b1, 32'h0, 32'h1111_1111, 1'b1, n, t1);
        ldr_txn(1'b1, 32'h4, 32'h2222_2222, 1'b1, n, t1);
        ldr_txn(1'b1, 32'h8, 32'h3333_3333, 1'b0, n, t2);
      end
      begin
        @(negedge clk);
        core_txn(1'b0, 32'h214, '0, n3, t3);
      end
    join
    check("lock_core_after_burst", t3 - t2, 3);
    ldr_txn(1'b0, 32'h4, '0, 1'b0, n, t1);

    // Core store with a 3-cycle memory; c_rdata must keep its old value
    fixed_lat = 3;
    fork
      core_txn(1'b1, 32'h20, 32'hCAFE_F00D, n, t1);
      begin
        repeat (2) @(negedge clk);
        check("wr_m_req", 32'(m_req), 1);
        check("wr_m_we", 32'(m_we), 1);
        check("wr_m_wdata", m_wdata, 32'hCAFE_F00D);
        check("wr_m_addr", m_addr, 32'h20);
      end
    join
    check("wr_latency", n, 5);
    fixed_lat = 0;
    core_txn(1'b0, 32'h20, '0, n, t1);

    // Hung memory on a loader read
    hang = 1;
    ldr_txn(1'b0, 32'h40, '0, 1'b0, n, t1);
    check("timeout_latency", n, TIMEOUT + 1);
    check("timeout_err_set", 32'(timeout_err), 1);
    hang = 0;
    core_txn(1'b1, 32'h240, 32'h0BAD_F00D, n, t1);
    core_txn(1'b0, 32'h240, '0, n, t1);
    check("timeout_err_sticky", 32'(timeout_err), 1);

    // Reset two cycles into a CORE wait
    hang = 1;
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h230;
    repeat (2) @(negedge clk);
    check("pre_rst_m_req", 32'(m_req), 1);
    reset = 1'b1;
    #1;
    check("midrst_m_req", 32'(m_req), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_c_ack", 32'(c_ack), 0);
    check("midrst_timeout_err", 32'(timeout_err), 0);
    c_req = 1'b0;
    hang = 0;
    @(negedge clk);
    reset = 1'b0;
    last_c = '0;
    last_l = '0;
    ldr_txn(1'b0, 32'h310, '0, 1'b0, n, t1);
    check("post_rst_latency", n, 2);

    // Random concurrent traffic from both requesters
    rand_lat = 1;
    fork
      begin : core_rand
        int nn, tt;
        repeat (40) begin
          core_txn(1'($urandom_range(0, 1)), 32'h200 + 32'(4 * $urandom_range(0, 15)),
                   $urandom, nn, tt);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin : ldr_rand
        int nn, tt;
        repeat (40) begin
          ldr_txn(1'($urandom_range(0, 1)), 32'h300 + 32'(4 * $urandom_range(0, 15)),
                  $urandom, 1'($urandom_range(0, 1)), nn, tt);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    join
    repeat (3) @(negedge clk);
    check("c_q_drained", c_q.size(), 0);
    check("l_q_drained", l_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
